// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared states and constants for the system-ID checker
package sysid_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_REPORT = 2'd3
  } sysid_chk_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   SYSID_DATA_W  = 32;

endpackage

// File: rtl/sysid_wait_timer.sv
// rtl/sysid_wait_timer.sv - bounded stall counter for one Avalon read
module sysid_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_q;

  assign expired_o = (count_q >= LIMIT);

  // Count stalled cycles; hold once the limit is reached so the counter never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads the system-ID slave and checks both words
module sysid_checker
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1378862049,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  sysid_chk_state_t        state_q;
  logic                    avm_address_q;
  logic                    avm_read_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    id_ok_q;
  logic                    ts_ok_q;
  logic                    timeout_q;
  logic [SYSID_DATA_W-1:0] id_value_q;
  logic [SYSID_DATA_W-1:0] ts_value_q;
  logic                    auto_q;

  logic timer_clear_d;
  logic timer_enable_d;
  logic timer_expired;

  // The timer restarts whenever no read is stalled: idle/report cycles, and the
  // completing cycle of the ID read, which is also the entry into the TS read.
  assign timer_enable_d = avm_read_q && avm_waitrequest;
  assign timer_clear_d  = !avm_read_q || !avm_waitrequest;

  sysid_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (timer_clear_d),
    .enable_i (timer_enable_d),
    .expired_o(timer_expired)
  );

  // Check sequencer: two reads, compare, one-cycle report; all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      avm_address_q <= SYSID_ADDR_ID;
      avm_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      auto_q        <= AUTO_START;
    end else begin
      done_q <= 1'b0;
      auto_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start || auto_q) begin
            state_q       <= ST_RD_ID;
            avm_read_q    <= 1'b1;
            avm_address_q <= SYSID_ADDR_ID;
            busy_q        <= 1'b1;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
          end
        end
        ST_RD_ID: begin
          if (timer_expired) begin
            state_q       <= ST_REPORT;
            avm_read_q    <= 1'b0;
            avm_address_q <= SYSID_ADDR_ID;
            timeout_q     <= 1'b1;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            done_q        <= 1'b1;
          end else if (!avm_waitrequest) begin
            state_q       <= ST_RD_TS;
            avm_address_q <= SYSID_ADDR_TS;
            id_value_q    <= avm_readdata;
            id_ok_q       <= (avm_readdata == EXPECTED_ID);
          end
        end
        ST_RD_TS: begin
          if (timer_expired) begin
            state_q       <= ST_REPORT;
            avm_read_q    <= 1'b0;
            avm_address_q <= SYSID_ADDR_ID;
            timeout_q     <= 1'b1;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            done_q        <= 1'b1;
          end else if (!avm_waitrequest) begin
            state_q       <= ST_REPORT;
            avm_read_q    <= 1'b0;
            avm_address_q <= SYSID_ADDR_ID;
            ts_value_q    <= avm_readdata;
            ts_ok_q       <= (avm_readdata == EXPECTED_TIMESTAMP);
            done_q        <= 1'b1;
          end
        end
        ST_REPORT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          avm_read_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM master that reads the 2-word system-ID slave (word 0 = system ID, word 1 = build timestamp) and compares both words against build-time expected values. It sits beside the Nios II on the same interconnect and gives software and board LEDs a hardware-level check that the loaded image matches the generated system. A bounded wait on `avm_waitrequest` prevents a missing or stalled slave from hanging the check.

## Interface

- `EXPECTED_ID`, 0, expected 32-bit value at word 0
- `EXPECTED_TIMESTAMP`, 1378862049, expected 32-bit value at word 1
- `TIMEOUT_CYCLES`, 255, maximum stalled cycles per read; range 1..65535
- `AUTO_START`, 1, when 1 a check starts automatically after reset release

- `clock`  in  1  single clock; all logic on its rising edge
- `reset_n`  in  1  reset; asynchronous assert, active-low
- `start`  in  1  request a check; sampled only in IDLE
- `avm_address`  out  1  word select; 0 = ID, 1 = timestamp
- `avm_read`  out  1  read strobe
- `avm_waitrequest`  in  1  slave stall; tie 0 for a zero-wait slave
- `avm_readdata`  in  32  read data, valid in the cycle `avm_read`=1 and `avm_waitrequest`=0
- `busy`  out  1  check in progress
- `done`  out  1  one-cycle pulse at the end of each check
- `id_ok`  out  1  word 0 matched `EXPECTED_ID`
- `ts_ok`  out  1  word 1 matched `EXPECTED_TIMESTAMP`
- `timeout`  out  1  the last check aborted on a stall
- `id_value`  out  32  captured word 0
- `ts_value`  out  32  captured word 1

## Operation

- States: IDLE, RD_ID, RD_TS, REPORT.
- IDLE: `avm_read`=0 and `busy`=0. A check begins on `start`=1, or on the first cycle after reset release when `AUTO_START`=1, and the FSM moves to RD_ID. Beginning a check clears `id_ok`, `ts_ok`, `timeout`, `id_value` and `ts_value`.
- RD_ID: `avm_read`=1, `avm_address`=0. Both stay stable while `avm_waitrequest`=1. On the first cycle with `avm_waitrequest`=0, `avm_readdata` is captured into `id_value`, `id_ok` is registered as (`avm_readdata`==`EXPECTED_ID`), and the FSM moves to RD_TS.
- RD_TS: same handshake with `avm_address`=1. The capture goes to `ts_value` and `ts_ok`, and the FSM moves to REPORT.
- REPORT: `done`=1 for one cycle, then IDLE. `start` is ignored in REPORT.
- Wait timer: cleared on entry to each read state. It increments on each cycle that has `avm_read`=1 and `avm_waitrequest`=1. When it reaches `TIMEOUT_CYCLES`, that cycle deasserts the read, sets `timeout`=1, forces `id_ok` and `ts_ok` to 0, and moves to REPORT. Any value already captured is retained.
- `start` while `busy`=1 is ignored; there is no queuing.
- Results hold until the next check begins.
- `reset_n` low mid-check aborts the check immediately. All outputs return to reset values. No `done` pulse is produced for an aborted check.

## Timing

- Reset values: state IDLE; `avm_read`, `avm_address`, `busy`, `done`, `id_ok`, `ts_ok`, `timeout` all 0; `id_value` and `ts_value` 0.
- All outputs are registered; none depend combinationally on `avm_waitrequest` or `avm_readdata`.
- Zero-wait slave: `start` is sampled at edge N. `avm_read`=1 with address 0 during cycle N+1, then address 1 during N+2. `done`=1 during N+3. Total latency is 3 cycles.
- Each wait-state cycle adds one cycle to the read in progress.
- `busy`=1 from the cycle after the start edge through the REPORT cycle inclusive.
- Timeout latency: `done` asserts `TIMEOUT_CYCLES`+1 cycles after the read strobe first asserts.

## Structure

- Package `sysid_check_pkg` holds:
  - the state enum `sysid_chk_state_t`
  - constants `SYSID_ADDR_ID`=0, `SYSID_ADDR_TS`=1, `SYSID_DATA_W`=32
- One sub-module, `sysid_wait_timer`: a 16-bit counter with `clear`, `enable` and `TIMEOUT_CYCLES` compare, producing an `expired` level.
- The FSM and comparators live in the top module.

## Test plan

- Zero-wait slave returning 0 / 1378862049, `AUTO_START`=1 → after reset release, `done` pulses 3 cycles after the first IDLE cycle; `id_ok`=1, `ts_ok`=1, `timeout`=0.
- Slave returns timestamp 0x12345678 → `ts_ok`=0, `id_ok`=1, `ts_value`=0x12345678.
- `avm_waitrequest` held high for 4 cycles on each read → address and read stay stable during the stalls; `done` arrives 11 cycles after `start`; both ok flags are 1.
- `avm_waitrequest` stuck high, `TIMEOUT_CYCLES`=8 → `done` arrives 9 cycles after the read asserts; `timeout`=1, both ok flags 0; read is deasserted in the `done` cycle.
- `start` pulsed during RD_TS and during REPORT → ignored, exactly one `done`. `start` in the following IDLE cycle → a new check begins and the old flags clear.
- `reset_n` low during RD_ID stall → outputs go to 0 asynchronously. After release with `AUTO_START`=0, no read is issued until `start`.
